// File: rtl/seg_mux_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_mux_decoder_if
// Purpose  : Bundles the scanned display bus that seg_mux_decoder samples and
//            the decoded results it returns.
// Ports    : master - drives en/seg/dp/disp_en/clr_err, reads the results
//            slave  - the decoder side (reads the bus, drives the results)
// Revision : 1.0 - initial release
// ============================================================================
interface seg_mux_decoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   disp_en;
  logic                    clr_err;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   bad;
  logic                    err;
  logic                    frame_valid;

  modport master (
    output en, seg, dp, disp_en, clr_err,
    input  digits, dp_out, blank, bad, err, frame_valid
  );

  modport slave (
    input  en, seg, dp, disp_en, clr_err,
    output digits, dp_out, blank, bad, err, frame_valid
  );
endinterface
`default_nettype wire

// File: rtl/seg_mux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_mux_decoder
// Purpose  : Monitors a multiplexed 7-segment display bus, waits for each
//            scanned digit to settle, decodes the glyph back to BCD and
//            rebuilds the displayed value; flags illegal glyphs.
// Ports    : clk, rst_n (async, active low)
//            bus (seg_mux_decoder_if.slave):
//              in : en, seg[6:0] (a=bit0), dp, disp_en[NUM_DIGITS], clr_err
//              out: digits[4*NUM_DIGITS], dp_out, blank, bad, err, frame_valid
// Config   : SEGDEC_HEX_EN - when defined, glyphs A b C d E F decode to
//            0xA..0xF instead of being illegal.
// Revision : 1.0 - initial release
// ============================================================================
module seg_mux_decoder #(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int EN_ACTIVE_LOW  = 0
) (
  input logic              clk,
  input logic              rst_n,
  seg_mux_decoder_if.slave bus
);

`ifdef SEGDEC_HEX_EN
  localparam bit c_HEX_EN = 1'b1;
`else
  localparam bit c_HEX_EN = 1'b0;
`endif

  localparam int                    c_CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]    c_SETTLE = c_CNT_W'(SETTLE_CYCLES);
  localparam logic [c_CNT_W-1:0]    c_CNT1   = c_CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] c_ONE    = NUM_DIGITS'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  // {bad, blank, value[3:0]}
  function automatic logic [5:0] f_decode(input logic [6:0] g);
    case (g)
      7'h3F:   f_decode = 6'h00;
      7'h06:   f_decode = 6'h01;
      7'h5B:   f_decode = 6'h02;
      7'h4F:   f_decode = 6'h03;
      7'h66:   f_decode = 6'h04;
      7'h6D:   f_decode = 6'h05;
      7'h7D:   f_decode = 6'h06;
      7'h07:   f_decode = 6'h07;
      7'h7F:   f_decode = 6'h08;
      7'h6F:   f_decode = 6'h09;
      7'h77:   f_decode = c_HEX_EN ? 6'h0A : 6'h20;
      7'h7C:   f_decode = c_HEX_EN ? 6'h0B : 6'h20;
      7'h39:   f_decode = c_HEX_EN ? 6'h0C : 6'h20;
      7'h5E:   f_decode = c_HEX_EN ? 6'h0D : 6'h20;
      7'h79:   f_decode = c_HEX_EN ? 6'h0E : 6'h20;
      7'h71:   f_decode = c_HEX_EN ? 6'h0F : 6'h20;
      7'h00:   f_decode = 6'h10;
      default: f_decode = 6'h20;
    endcase
  endfunction

  // Input stage, polarity normalised so everything downstream is active high
  logic [6:0]            r_seg, r_last_seg;
  logic                  r_dp, r_last_dp;
  logic [NUM_DIGITS-1:0] r_sel, r_last_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg      <= '0;
      r_dp       <= 1'b0;
      r_sel      <= '0;
      r_last_seg <= '0;
      r_last_dp  <= 1'b0;
      r_last_sel <= '0;
    end else begin
      r_seg      <= (SEG_ACTIVE_LOW != 0) ? ~bus.seg : bus.seg;
      r_dp       <= (SEG_ACTIVE_LOW != 0) ? ~bus.dp  : bus.dp;
      r_sel      <= (EN_ACTIVE_LOW  != 0) ? ~bus.disp_en : bus.disp_en;
      // Sample the FSM evaluated last edge, for the "unchanged" test
      r_last_seg <= r_seg;
      r_last_dp  <= r_dp;
      r_last_sel <= r_sel;
    end
  end

  logic w_onehot, w_same;
  assign w_onehot = (r_sel != '0) && ((r_sel & (r_sel - c_ONE)) == '0);
  assign w_same   = ({r_seg, r_dp, r_sel} == {r_last_seg, r_last_dp, r_last_sel});

  // ---------------- FSM: state register ----------------
  logic [1:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!bus.en || !w_onehot) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = c_CNT1;
        end
        S_SETTLE: begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = w_same ? (r_cnt + c_CNT1) : c_CNT1;
        end
        S_HOLD: begin
          if (!w_same) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = c_CNT1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      // Reaching the settle count captures on this same edge
      if (w_state_nxt == S_SETTLE && w_cnt_nxt == c_SETTLE)
        w_state_nxt = S_HOLD;
    end
  end

  // ---------------- FSM: outputs ----------------
  logic                  w_capture, w_frame_done;
  logic [5:0]            w_dec;
  logic [NUM_DIGITS-1:0] r_seen, w_seen_upd;

  always_comb begin
    // Entering HOLD from anywhere except a quiet HOLD means a fresh capture
    w_capture    = (w_state_nxt == S_HOLD) && !((r_state == S_HOLD) && w_same);
    w_dec        = f_decode(r_seg);
    w_seen_upd   = r_seen | r_sel;
    w_frame_done = w_capture && (&w_seen_upd);
  end

  // ---------------- Capture datapath ----------------
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp_out, r_blank, r_bad;
  logic                    r_err, r_frame_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits      <= '0;
      r_dp_out      <= '0;
      r_blank       <= '1;
      r_bad         <= '0;
      r_err         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_seen        <= '0;
    end else begin
      r_frame_valid <= w_frame_done;
      if (!bus.en)
        r_seen <= '0;
      else if (w_capture)
        r_seen <= w_frame_done ? '0 : w_seen_upd;
      if (w_capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_sel[i]) begin
            r_digits[4*i +: 4] <= w_dec[3:0];
            r_blank[i]         <= w_dec[4];
            r_bad[i]           <= w_dec[5];
            r_dp_out[i]        <= r_dp;
          end
        end
      end
      // A new illegal capture wins over a simultaneous clear
      if (w_capture && w_dec[5])
        r_err <= 1'b1;
      else if (bus.clr_err)
        r_err <= 1'b0;
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dp_out      = r_dp_out;
  assign bus.blank       = r_blank;
  assign bus.bad         = r_bad;
  assign bus.err         = r_err;
  assign bus.frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_mux_decoder
// Purpose  : Self-checking bench for seg_mux_decoder: glyph table, directed
//            corner sequences and random scanning against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_mux_decoder;
  localparam int ND = 8;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_mux_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_mux_decoder #(
    .NUM_DIGITS(ND), .SETTLE_CYCLES(ST), .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

`ifdef SEGDEC_HEX_EN
  localparam int NGL = 16;
`else
  localparam int NGL = 10;
`endif
  localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_assert = 0;
  int n_fail   = 0;
  int fv_count = 0;

  // ---------------- reference model ----------------
  logic [6:0]      m_seg_q, m_pseg;
  logic            m_dp_q, m_pdp;
  logic [ND-1:0]   m_sel_q, m_psel;
  int              m_run;
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_dpo, m_blank, m_bad, m_seen;
  logic            m_err, m_fv;

  function automatic void ref_decode(input logic [6:0] g, output logic [3:0] v,
                                     output logic bl, output logic bd);
    v = 4'h0; bl = 1'b0; bd = 1'b0;
    if (g == 7'h00) begin bl = 1'b1; return; end
    for (int k = 0; k < NGL; k++)
      if (GL[k] == g) begin v = k[3:0]; return; end
    bd = 1'b1;
  endfunction

  task automatic model_reset();
    m_seg_q = '0; m_dp_q = 1'b0; m_sel_q = '0;
    m_pseg = '0;  m_pdp = 1'b0;  m_psel = '0;
    m_run = 0;
    m_digits = '0; m_dpo = '0; m_blank = '1; m_bad = '0; m_seen = '0;
    m_err = 1'b0; m_fv = 1'b0;
  endtask

  // Predicts the state after the coming edge from the pins as they are now
  task automatic model_edge();
    logic cap, fv_n, bl, bd;
    logic [3:0] v;
    int idx;
    if (!rst_n) begin model_reset(); return; end
    cap = 1'b0; fv_n = 1'b0; idx = 0;
    if (!bus.en) m_run = 0;
    else if ($countones(m_sel_q) != 1) m_run = 0;
    else if (m_run > 0 && {m_seg_q, m_dp_q, m_sel_q} == {m_pseg, m_pdp, m_psel}) m_run++;
    else m_run = 1;
    cap = bus.en && (m_run == ST);
    for (int k = 0; k < ND; k++) if (m_sel_q[k]) idx = k;
    ref_decode(m_seg_q, v, bl, bd);
    if (cap) begin
      m_digits[4*idx +: 4] = v;
      m_blank[idx] = bl;
      m_bad[idx] = bd;
      m_dpo[idx] = m_dp_q;
    end
    if (cap && bd) m_err = 1'b1;
    else if (bus.clr_err) m_err = 1'b0;
    if (!bus.en) m_seen = '0;
    else if (cap) begin
      m_seen[idx] = 1'b1;
      if (&m_seen) begin m_seen = '0; fv_n = 1'b1; end
    end
    m_fv = fv_n;
    m_pseg = m_seg_q; m_pdp = m_dp_q; m_psel = m_sel_q;
    m_seg_q = bus.seg; m_dp_q = bus.dp; m_sel_q = bus.disp_en;
  endtask

  // ---------------- checking helpers ----------------
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_model();
    chk("digits", 64'(bus.digits), 64'(m_digits));
    chk("dp_out", 64'(bus.dp_out), 64'(m_dpo));
    chk("blank",  64'(bus.blank),  64'(m_blank));
    chk("bad",    64'(bus.bad),    64'(m_bad));
    chk("err",    64'(bus.err),    64'(m_err));
    chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
  endfunction

  function automatic void check_reset_consts();
    chk("rst_digits", 64'(bus.digits), 64'd0);
    chk("rst_dp_out", 64'(bus.dp_out), 64'd0);
    chk("rst_blank",  64'(bus.blank),  64'hFF);
    chk("rst_bad",    64'(bus.bad),    64'd0);
    chk("rst_err",    64'(bus.err),    64'd0);
    chk("rst_fv",     64'(bus.frame_valid), 64'd0);
  endfunction

  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      model_edge();
      @(posedge clk);
      #1;
      if (bus.frame_valid) fv_count++;
      check_model();
    end
  endtask

  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] s, input logic d);
    bus.disp_en = sel; bus.seg = s; bus.dp = d;
  endtask

  // ---------------- glyph table ----------------
  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       blank;
    logic       bad;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{7'h3F, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{7'h06, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{7'h5B, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{7'h4F, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{7'h66, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{7'h6D, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{7'h7D, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{7'h07, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{7'h7F, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{7'h6F, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{7'h00, 4'h0, 1'b1, 1'b0};
    tbl[11] = '{7'h08, 4'h0, 1'b0, 1'b1};
`ifdef SEGDEC_HEX_EN
    tbl[12] = '{7'h71, 4'hF, 1'b0, 1'b0};
`else
    tbl[12] = '{7'h71, 4'h0, 1'b0, 1'b1};
`endif

    bus.en = 1'b0; bus.clr_err = 1'b0;
    drive('0, '0, 1'b0);
    model_reset();

    // Reset asserted mid-cycle takes effect immediately
    #2 rst_n = 1'b0;
    #1 check_reset_consts();
    tick(2);
    rst_n = 1'b1;
    bus.en = 1'b1;

    // Reset in the middle of a dwell abandons the partial capture
    drive(8'h02, 7'h06, 1'b1);
    tick(3);
    #3 rst_n = 1'b0;
    #1 check_reset_consts();
    model_reset();
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("after_rst_dig1", 64'(bus.digits[7:4]), 64'h1);
    chk("after_rst_dp1", 64'(bus.dp_out[1]), 64'h1);

    // Held four edges: no update; five edges: captured
    drive(8'h01, 7'h5B, 1'b0);
    tick(4);
    drive('0, '0, 1'b0);
    chk("hold4_nocap", 64'(bus.digits[3:0]), 64'h0);
    tick(3);
    drive(8'h01, 7'h5B, 1'b0);
    tick(5);
    chk("hold5_cap", 64'(bus.digits[3:0]), 64'h2);

    // Full scan of digits 0..7 from the glyph table
    fv_count = 0;
    for (int i = 0; i < ND; i++) begin
      drive(ND'(1) << i, tbl[i].seg, 1'b0);
      tick(8);
      chk("scan_digit", 64'(bus.digits[4*i +: 4]), 64'(tbl[i].dig));
    end
    tick(1);
    chk("scan_value", 64'(bus.digits), 64'h76543210);
    chk("scan_fv_count", 64'(fv_count), 64'd1);

    // Remaining table entries on digit 2
    for (int i = 8; i < 13; i++) begin
      drive(8'h04, tbl[i].seg, 1'b1);
      tick(6);
      chk("tbl_digit", 64'(bus.digits[11:8]), 64'(tbl[i].dig));
      chk("tbl_blank", 64'(bus.blank[2]), 64'(tbl[i].blank));
      chk("tbl_bad",   64'(bus.bad[2]),   64'(tbl[i].bad));
      drive('0, '0, 1'b0);
      tick(2);
    end
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;

    // Restore a known value, then glitch patterns must not capture
    for (int i = 0; i < ND; i++) begin
      drive(ND'(1) << i, tbl[i].seg, 1'b0);
      tick(6);
    end
    drive(8'h03, 7'h3F, 1'b0);
    tick(10);
    for (int r = 0; r < 6; r++) begin
      drive(8'h01, r[0] ? 7'h07 : 7'h06, 1'b0);
      tick(3);
    end
    chk("glitch_nocap", 64'(bus.digits), 64'h76543210);

    // Hex glyph on digit 2, then clr_err colliding with a new illegal capture
    drive('0, '0, 1'b0); tick(2);
    drive(8'h04, 7'h77, 1'b0);
    tick(6);
`ifdef SEGDEC_HEX_EN
    chk("hex_A_digit", 64'(bus.digits[11:8]), 64'hA);
    chk("hex_A_err", 64'(bus.err), 64'h0);
`else
    chk("hex_A_bad", 64'(bus.bad[2]), 64'h1);
    chk("hex_A_err", 64'(bus.err), 64'h1);
`endif
    drive(8'h08, 7'h08, 1'b0);
    tick(4);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("clr_vs_bad_err", 64'(bus.err), 64'h1);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0;
    chk("clr_err", 64'(bus.err), 64'h0);

    // en dropped part way through a scan, then a full scan in rotated order
    for (int i = 0; i < 5; i++) begin
      drive(ND'(1) << i, tbl[i].seg, 1'b0);
      tick(6);
    end
    bus.en = 1'b0; tick(4); bus.en = 1'b1;
    fv_count = 0;
    for (int j = 0; j < ND; j++) begin
      int i;
      i = (j + 5) % ND;
      drive(ND'(1) << i, tbl[i].seg, 1'b0);
      tick(6);
      if (j == ND - 2) chk("en_drop_no_early_fv", 64'(fv_count), 64'd0);
    end
    tick(1);
    chk("en_drop_fv_count", 64'(fv_count), 64'd1);

    // Random scanning against the model
    for (int r = 0; r < 150; r++) begin
      logic [ND-1:0] sel;
      logic [6:0] s;
      int dwell;
      sel = ($urandom_range(0, 9) != 0) ? (ND'(1) << $urandom_range(0, ND-1)) : ND'($urandom);
      s = ($urandom_range(0, 4) != 0) ? GL[$urandom_range(0, 15)] : 7'($urandom);
      drive(sel, s, 1'($urandom));
      bus.en = ($urandom_range(0, 19) != 0);
      dwell = $urandom_range(1, 9);
      for (int t = 0; t < dwell; t++) begin
        bus.clr_err = ($urandom_range(0, 9) == 0);
        tick(1);
      end
    end
    bus.clr_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
